// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the audio playback path.
//   SAMPLE_BITS / VOLUME_BITS : default sample and gain widths
//   M_BUF_LEN                 : default master playback ring-buffer depth
//   FREQ_RES_BITS             : oscillator phase-step resolution
//   sample_t                  : signed audio sample
//   SourceControlReg_t        : per-source control register layout
//   mix_state_t               : mixer sequencing states
// ---------------------------------------------------------------------------
package audio_pkg;

  localparam int SAMPLE_BITS   = 16;
  localparam int VOLUME_BITS   = 8;
  localparam int M_BUF_LEN     = 256;
  localparam int FREQ_RES_BITS = 24;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;

  // Control word for one audio source (DMA stream or oscillator).
  typedef struct packed {
    logic                     enable;
    logic [VOLUME_BITS-1:0]   volume;
    logic [FREQ_RES_BITS-1:0] freq_step;
  } SourceControlReg_t;

  typedef enum logic [1:0] {
    MIX_IDLE  = 2'd0,
    MIX_ACCUM = 2'd1,
    MIX_WRITE = 2'd2
  } mix_state_t;

endpackage

// File: rtl/lrclk_edge_detect.sv
// ---------------------------------------------------------------------------
// lrclk_edge_detect
// Brings the asynchronous I2S frame clock into the mclk domain and emits a
// one-cycle pulse for every falling edge.
//   mclk  in  : audio master clock
//   rst   in  : synchronous active-high reset
//   lrclk in  : I2S frame clock, asynchronous to mclk
//   tick  out : registered one-cycle pulse per lrclk falling edge
// The synchroniser and history flops reset to 1 so that an lrclk that is
// already low when reset releases still produces exactly one tick.
// ---------------------------------------------------------------------------
module lrclk_edge_detect (
  input  logic mclk,
  input  logic rst,
  input  logic lrclk,
  output logic tick
);

  import audio_pkg::*;

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  always_ff @(posedge mclk) begin
    if (rst) begin
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      sync_prev <= 1'b1;
      tick      <= 1'b0;
    end else begin
      sync_1    <= lrclk;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      // falling edge: previous synchronised level high, current low
      tick      <= sync_prev & ~sync_2;
    end
  end

endmodule

// File: rtl/audio_mix_engine.sv
// ---------------------------------------------------------------------------
// audio_mix_engine
// N-channel serial multiply-accumulate mixer feeding the master playback
// ring buffer. Once per I2S frame it snapshots every channel, accumulates
// one channel per mclk and writes one mixed sample LAG entries behind the
// player's read index.
//
// Ports:
//   mclk        in  : audio master clock (sole clock)
//   rst         in  : synchronous active-high reset
//   lrclk       in  : I2S frame clock, asynchronous, synchronised inside
//   play_index  in  : player's current read index
//   ch_sample   in  : NUM_CH signed samples, channel 0 in the low bits
//   ch_vol      in  : NUM_CH unsigned gains, full scale = 2^VOLUME_BITS
//   ch_valid    in  : per-channel enable, disabled channels contribute 0
//   clr_flags   in  : clears clip and overrun (a same-cycle set wins)
//   wr_en       out : one-cycle buffer write strobe
//   wr_addr     out : buffer write address, held until the next write
//   wr_data     out : mixed sample, held until the next write
//   busy        out : mix in progress
//   clip        out : sticky, a mix saturated (saturating build only)
//   overrun     out : sticky, a frame tick arrived while busy
//
// Build option: define AUDIO_MIX_SATURATE_EN to clamp the mix to the sample
// range and report clamping on clip; otherwise the mix wraps to its low
// SAMPLE_BITS, matching the old two-source combinator, and clip stays 0.
// ---------------------------------------------------------------------------
module audio_mix_engine #(
  parameter int NUM_CH      = 4,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8,
  parameter int BUF_LEN     = 256,
  parameter int LAG         = 1
) (
  input  logic                            mclk,
  input  logic                            rst,
  input  logic                            lrclk,
  input  logic [$clog2(BUF_LEN)-1:0]      play_index,
  input  logic [NUM_CH*SAMPLE_BITS-1:0]   ch_sample,
  input  logic [NUM_CH*VOLUME_BITS-1:0]   ch_vol,
  input  logic [NUM_CH-1:0]               ch_valid,
  input  logic                            clr_flags,
  output logic                            wr_en,
  output logic [$clog2(BUF_LEN)-1:0]      wr_addr,
  output logic [SAMPLE_BITS-1:0]          wr_data,
  output logic                            busy,
  output logic                            clip,
  output logic                            overrun
);

  import audio_pkg::*;

  localparam int AW      = $clog2(BUF_LEN);
  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int P_W     = SAMPLE_BITS + VOLUME_BITS + 1;
  // one guard bit per doubling of channel count plus the gain sign bit,
  // so a full-scale sum of every channel cannot overflow
  localparam int ACC_W   = SAMPLE_BITS + VOLUME_BITS + $clog2(NUM_CH) + 1;
  localparam int LAST_CH = NUM_CH - 1;

  // -------------------------------------------------------------------------
  // Arithmetic helpers
  // -------------------------------------------------------------------------

  // signed sample times zero-extended gain, widened to the accumulator
  function automatic logic signed [ACC_W-1:0] mac_term(
    input logic signed [SAMPLE_BITS-1:0] s,
    input logic        [VOLUME_BITS-1:0] g,
    input logic                          en
  );
    logic signed [P_W-1:0] p;
    p = P_W'(s) * P_W'($signed({1'b0, g}));
    return en ? ACC_W'(p) : '0;
  endfunction

`ifdef AUDIO_MIX_SATURATE_EN
  localparam logic signed [ACC_W-1:0] S_MAX =
    ACC_W'((64'sd1 <<< (SAMPLE_BITS - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

  // floor-scale by the gain full scale, then clamp to the sample range
  function automatic logic [SAMPLE_BITS-1:0] reduce_mix(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] q;
    q = a >>> VOLUME_BITS;
    if (q > S_MAX) begin
      return S_MAX[SAMPLE_BITS-1:0];
    end else if (q < S_MIN) begin
      return S_MIN[SAMPLE_BITS-1:0];
    end
    return q[SAMPLE_BITS-1:0];
  endfunction

  function automatic logic mix_saturates(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0] q;
    q = a >>> VOLUME_BITS;
    return (q > S_MAX) || (q < S_MIN);
  endfunction
`else
  // floor-scale by the gain full scale and keep the low SAMPLE_BITS
  // (the bit slice of a two's-complement value is the floored shift)
  function automatic logic [SAMPLE_BITS-1:0] reduce_mix(
    input logic signed [ACC_W-1:0] a
  );
    return a[VOLUME_BITS +: SAMPLE_BITS];
  endfunction
`endif

  // -------------------------------------------------------------------------
  // Frame tick
  // -------------------------------------------------------------------------
  logic tick;

  lrclk_edge_detect u_edge (
    .mclk  (mclk),
    .rst   (rst),
    .lrclk (lrclk),
    .tick  (tick)
  );

  // -------------------------------------------------------------------------
  // Stage p0: frame snapshot of all channel inputs and the write address
  // -------------------------------------------------------------------------
  mix_state_t                    state;
  logic [CW-1:0]                 ch_idx;
  logic signed [SAMPLE_BITS-1:0] samp_p0  [NUM_CH];
  logic [VOLUME_BITS-1:0]        vol_p0   [NUM_CH];
  logic [NUM_CH-1:0]             valid_p0;
  logic [AW-1:0]                 addr_p0;
  logic                          snap;

  assign snap = (state == MIX_IDLE) && tick;

  always_ff @(posedge mclk) begin
    if (snap) begin
      for (int i = 0; i < NUM_CH; i++) begin
        samp_p0[i] <= $signed(ch_sample[i*SAMPLE_BITS +: SAMPLE_BITS]);
        vol_p0[i]  <= ch_vol[i*VOLUME_BITS +: VOLUME_BITS];
      end
      valid_p0 <= ch_valid;
      // modular subtraction wraps the write-behind address naturally
      addr_p0  <= play_index - AW'(LAG);
    end
  end

  // -------------------------------------------------------------------------
  // Stage p1: serial accumulate, one channel per cycle
  // -------------------------------------------------------------------------
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [SAMPLE_BITS-1:0]   mix_out;
  logic                     last_step;

  always_comb begin
    acc_sum = acc_p1 + mac_term(samp_p0[ch_idx], vol_p0[ch_idx],
                                valid_p0[ch_idx]);
    mix_out = reduce_mix(acc_sum);
  end

  assign last_step = (state == MIX_ACCUM) && (ch_idx == CW'(LAST_CH));

  // The final product is folded in combinationally on the last ACCUM cycle
  // so the write strobe and data land together on the WRITE cycle.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state   <= MIX_IDLE;
      ch_idx  <= '0;
      acc_p1  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        MIX_IDLE: begin
          if (tick) begin
            acc_p1 <= '0;
            ch_idx <= '0;
            busy   <= 1'b1;
            state  <= MIX_ACCUM;
          end
        end
        MIX_ACCUM: begin
          acc_p1 <= acc_sum;
          if (ch_idx == CW'(LAST_CH)) begin
            wr_en   <= 1'b1;
            wr_addr <= addr_p0;
            wr_data <= mix_out;
            state   <= MIX_WRITE;
          end else begin
            ch_idx <= ch_idx + CW'(1);
          end
        end
        MIX_WRITE: begin
          busy  <= 1'b0;
          state <= MIX_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= MIX_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stage p2: sticky status flags
  // -------------------------------------------------------------------------
  logic overrun_set;

  // a tick outside IDLE is dropped; the mix in flight is left untouched
  assign overrun_set = tick && (state != MIX_IDLE);

  always_ff @(posedge mclk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (clr_flags) begin
      overrun <= 1'b0;
    end
  end

`ifdef AUDIO_MIX_SATURATE_EN
  logic clip_set;

  assign clip_set = last_step && mix_saturates(acc_sum);

  always_ff @(posedge mclk) begin
    if (rst) begin
      clip <= 1'b0;
    end else if (clip_set) begin
      clip <= 1'b1;
    end else if (clr_flags) begin
      clip <= 1'b0;
    end
  end
`else
  logic unused_last_step;

  assign unused_last_step = last_step;
  assign clip             = 1'b0;
`endif

endmodule
